// File: rtl/router_pkg.sv
// Shared definitions for the mesh router input port: direction codes, request FSM
// encoding and packet field offsets for the {dst_x, dst_y, payload} layout.
package router_pkg;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_X     = 2'b01;
    localparam logic [1:0] DIR_Y     = 2'b10;
    localparam logic [1:0] DIR_LOCAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_BLOCKED = 2'b10
    } state_t;

    localparam int PAYLOAD_LSB = 0;

    function automatic int dst_y_lsb(input int addr_w, input int data_w);
        return data_w + 0 * addr_w;
    endfunction

    function automatic int dst_x_lsb(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO; the head is visible combinationally on rdata and the
// registered count distinguishes full from empty.
module router_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and count state; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are qualified by the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/router_inport.sv
// Mesh router input port: buffers packets, requests the XY route of the head and
// forwards on grant. Define ROUTER_INPORT_STARVE_EN to add the retry counter / starve flag.
module router_inport
    import router_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 2,
    parameter int DEPTH   = 4,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0,
    parameter int PKT_W   = 2 * ADDR_W + DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PKT_W-1:0]       in_pkt,
    output logic [1:0]             dir,
    output logic                   req_en,
    input  logic                   fail,
    output logic                   out_valid,
    output logic [PKT_W-1:0]       out_pkt,
    output logic [1:0]             out_dir,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef ROUTER_INPORT_STARVE_EN
    ,
    output logic                   starve
`endif
);
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int X_LSB = dst_x_lsb(ADDR_W, DATA_W);
    localparam int Y_LSB = dst_y_lsb(ADDR_W, DATA_W);
    localparam logic [ADDR_W-1:0] MY_X = ADDR_W'(LOCAL_X);
    localparam logic [ADDR_W-1:0] MY_Y = ADDR_W'(LOCAL_Y);

    logic [PKT_W-1:0]  head_s;
    logic              full_s;
    logic              empty_s;
    logic [OW-1:0]     occ_s;
    logic              push_s;
    logic              grant_s;
    logic              remain_s;
    logic [1:0]        route_s;
    logic [ADDR_W-1:0] head_x_s;
    logic [ADDR_W-1:0] head_y_s;
    state_t            state_r;
    state_t            state_next_s;
    logic              out_valid_r;
    logic [PKT_W-1:0]  out_pkt_r;
    logic [1:0]        out_dir_r;

    router_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (grant_s),
        .wdata (in_pkt),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (occ_s)
    );

    assign head_x_s = head_s[X_LSB +: ADDR_W];
    assign head_y_s = head_s[Y_LSB +: ADDR_W];
    assign in_ready = !full_s;
    assign push_s   = in_valid && !full_s;
    assign dir      = empty_s ? DIR_NONE : route_s;
    assign req_en   = (dir != DIR_NONE);
    assign grant_s  = req_en && !fail;
    // After a grant the FIFO stays non-empty if more than one entry was held or a push lands.
    assign remain_s = (occ_s > OW'(1)) || push_s;
    assign occupancy = occ_s;
    assign out_valid = out_valid_r;
    assign out_pkt   = out_pkt_r;
    assign out_dir   = out_dir_r;

    // XY dimension-order route of the FIFO head.
    always_comb begin
        route_s = DIR_LOCAL;
        if (head_x_s != MY_X) begin
            route_s = DIR_X;
        end else if (head_y_s != MY_Y) begin
            route_s = DIR_Y;
        end else begin
            route_s = DIR_LOCAL;
        end
    end

    // Request FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (push_s) state_next_s = ST_REQ;
                else        state_next_s = ST_IDLE;
            end
            ST_REQ, ST_BLOCKED: begin
                if (req_en && fail)  state_next_s = ST_BLOCKED;
                else if (grant_s)    state_next_s = remain_s ? ST_REQ : ST_IDLE;
                else if (empty_s)    state_next_s = ST_IDLE;
                else                 state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Forwarded packet register: one pulse per granted head.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_r <= 1'b0;
            out_pkt_r   <= {PKT_W{1'b0}};
            out_dir_r   <= DIR_NONE;
        end else begin
            out_valid_r <= grant_s;
            if (grant_s) begin
                out_pkt_r <= head_s;
                out_dir_r <= route_s;
            end
        end
    end

`ifdef ROUTER_INPORT_STARVE_EN
    logic [3:0] retry_cnt_r;
    logic [3:0] retry_next_s;
    logic       starve_r;

    // Saturating retry count of consecutive failed requests.
    always_comb begin
        retry_next_s = retry_cnt_r;
        if (grant_s) begin
            retry_next_s = 4'd0;
        end else if (req_en && fail && (state_r != ST_IDLE) && (retry_cnt_r != 4'd15)) begin
            retry_next_s = retry_cnt_r + 4'd1;
        end else begin
            retry_next_s = retry_cnt_r;
        end
    end

    // Retry counter and starve flag, both tracking the post-edge count.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            retry_cnt_r <= 4'd0;
            starve_r    <= 1'b0;
        end else begin
            retry_cnt_r <= retry_next_s;
            starve_r    <= (retry_next_s == 4'd15);
        end
    end

    assign starve = starve_r;
`endif

endmodule

// File: doc/router_inport.md
Name: router_inport

Overview:
- Per-input-port request side of the mesh router.
- Buffers incoming packets and computes the XY route of the head packet.
- Drives the 2-bit direction code (00 NONE, 01 X, 10 Y, 11 LOCAL) into the conflict judge, then reacts to that port's fail bit: pop and forward on success, hold and retry on failure.
- One instance per router input (X, Y, LOCAL) feeds the judge's three direction inputs.

Parameters:
- DATA_W, 16, payload width.
- ADDR_W, 2, width of one coordinate (dst_x, dst_y).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- LOCAL_X, 0, this router's x coordinate.
- LOCAL_Y, 0, this router's y coordinate.
- Derived: PKT_W = 2*ADDR_W + DATA_W.
- Packet layout: {dst_x, dst_y, payload}, dst_x in the MSBs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high; clock clk.
- in_valid  in  1  upstream packet valid.
- in_ready  out  1  FIFO can accept; = !full, registered-count based, no path from fail.
- in_pkt  in  PKT_W  upstream packet.
- dir  out  2  direction request to judge; 00 when FIFO empty.
- req_en  out  1  = (dir != 00); drives the judge enable so priorities update only on real requests.
- fail  in  1  this port's fail bit from the judge, same-cycle combinational.
- out_valid  out  1  forwarded packet valid, one-cycle pulse per packet.
- out_pkt  out  PKT_W  forwarded packet.
- out_dir  out  2  direction the forwarded packet takes; crossbar select.
- occupancy  out  log2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (rst_n=1, async):
  - FIFO flushed, occupancy=0.
  - dir=00, req_en=0, out_valid=0, out_pkt=0, out_dir=00, in_ready=1.
  - FSM to IDLE.
  - Mid-operation reset discards all buffered and in-flight packets, with no output pulse.
- Route, combinational on the FIFO head:
  - dst_x != LOCAL_X -> 01 (X).
  - else dst_y != LOCAL_Y -> 10 (Y).
  - else 11 (LOCAL).
  - Route is never 00 for a valid head.
- Push: in_valid && in_ready writes in_pkt at the tail on the clock edge. A push while full is impossible because in_ready=0.
- Grant: req_en && !fail at the edge.
  - Pops the head.
  - Next cycle: out_valid=1, out_pkt=head, out_dir=route.
  - Latency: a packet pushed into an empty FIFO is presented on dir the next cycle and can appear on out_valid one cycle after that (2 cycles minimum).
- Fail: req_en && fail at the edge. Head is kept and re-presented the next cycle with the same dir; no out_valid.
- Push and pop in the same cycle: both happen; occupancy unchanged.
- Push into empty: the head becomes valid the next cycle. Input is never bypassed to dir in the same cycle.
- Pointers: wrap modulo DEPTH; the full/empty distinction uses occupancy.
- FSM:
  - IDLE (empty) -> REQ on occupancy becoming nonzero.
  - REQ -> BLOCKED on fail.
  - REQ -> REQ on grant with occupancy>1 after pop.
  - REQ -> IDLE on grant emptying the FIFO, unless a push in the same cycle keeps occupancy nonzero.
  - BLOCKED -> REQ on grant.
  - BLOCKED -> BLOCKED on fail.
  - dir is identical in REQ and BLOCKED; the state only feeds the optional counter.
- fail is ignored when req_en=0.

Optional Feature:
- Macro: ROUTER_INPORT_STARVE_EN.
- Enabled:
  - 4-bit saturating retry counter, incremented on each fail in REQ/BLOCKED, cleared on grant and on reset.
  - Extra output starve (1 bit), registered, high while counter == 15.
- Disabled: no counter, no starve port. All other behaviour identical.

Decomposition:
- Package router_pkg holds:
  - direction constants DIR_NONE=2'b00, DIR_X=2'b01, DIR_Y=2'b10, DIR_LOCAL=2'b11;
  - FSM state encoding IDLE/REQ/BLOCKED;
  - packet field offset constants.
- Sub-module router_fifo: synchronous FIFO with parameters WIDTH, DEPTH; ports push, pop, wdata, rdata (head), full, empty, count.
- Route compute and FSM stay in router_inport.

Test Plan (LOCAL_X=1, LOCAL_Y=1, DEPTH=4):
- Push {dst_x=2,dst_y=1,payload=0xABCD}, fail=0 -> dir=01 next cycle; out_valid pulse one cycle later with out_pkt=that packet, out_dir=01; occupancy back to 0.
- Push dst (1,3) then (1,1), fail=0 -> dirs 10 then 11; out_dir sequence 10, 11 in order.
- Hold fail=1 for 3 cycles with one packet buffered -> dir stays 01, out_valid=0, state BLOCKED; drop fail -> single out_valid next cycle.
- Push 4 packets with fail=1 -> in_ready=0 at occupancy=4; a fifth in_valid is not accepted; release fail -> 4 packets out in FIFO order.
- Occupancy=2, push and grant in the same cycle -> occupancy stays 2, no loss; assert rst_n mid-stream -> out_valid=0, dir=00, occupancy=0 immediately.
- With ROUTER_INPORT_STARVE_EN: fail held 16 cycles -> starve=1 from the 15th fail onward; a grant clears it the next cycle.
